audio_prefetch: RTL
===================

Name: audio_prefetch

Overview:
- Sits between the SPI flash reader (valid/ready word interface) and the I2S serializer.
- Walks a PCM region of flash, 32-bit words (L in [31:16], R in [15:0]), and keeps a small FIFO of stereo words full.
- The serializer pops one word per frame; the serializer never waits on flash latency.
- Underruns are detected, muted and counted.

Parameters:
- BASE_ADDR, 24'h000000, byte address of the first stereo word.
- SIZE, 24'h0ea600, region length in bytes; must be a nonzero multiple of 4.
- DEPTH, 8, FIFO depth in words; power of 2, minimum 2.
- AW, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  high = fetching allowed.
- flash_valid  out  1  read request to the flash reader.
- flash_addr  out  24  byte address of the request.
- flash_ready  in  1  one-cycle pulse; flash_rdata valid in that cycle.
- flash_rdata  in  32  word read from flash.
- sample_req  in  1  one-cycle pop strobe from the serializer.
- sample_data  out  32  popped stereo word.
- sample_valid  out  1  one-cycle pulse; sample_data updated.
- underrun  out  1  one-cycle pulse: pop while empty.
- underrun_cnt  out  16  saturating underrun count.
- level  out  AW+1  FIFO occupancy, 0..DEPTH.
- done  out  1  region exhausted (loop disabled only).

Behaviour:
- Reset is synchronous, active-low on clk, and clears:
  - flash_valid=0, flash_addr=BASE_ADDR, sample_data=0, sample_valid=0, underrun=0, underrun_cnt=0, level=0, done=0.
  - FIFO pointers; state=S_IDLE.
- Reset mid-request drops flash_valid next edge. A flash_ready arriving in the reset cycle is discarded. The flash reader shares resetn.
- FSM states: S_IDLE, S_REQ, S_DONE.
  - S_IDLE -> S_REQ when enable=1 and level<DEPTH. flash_valid=1 from the next cycle, with flash_addr at the current fetch pointer.
  - S_REQ: flash_valid and flash_addr are held stable until flash_ready. At most one request is outstanding.
  - On flash_ready, flash_rdata is pushed at the write pointer, and the fetch pointer advances by 4 bytes.
  - If the advanced pointer equals BASE_ADDR+SIZE, end-of-region handling applies (see Optional Feature).
  - Then go to S_IDLE (or S_DONE), with flash_valid=0 for at least one cycle.
  - enable falling during S_REQ does not abort the request; it completes normally, and no new request is issued.
- Space rule: a request is issued only when level<DEPTH at issue time, so a push can never overflow.
- Pop:
  - sample_req with level>0: sample_data <= head word and sample_valid=1 on the next edge; the read pointer advances.
  - sample_req with level=0: sample_data <= 0 (mute), sample_valid=1, underrun=1. underrun_cnt increments and saturates at 16'hffff.
- Simultaneous push and pop in one cycle: both take effect; level is unchanged.
  - Pop at level=0 coincident with a push is still an underrun. The pushed word lands and level=1.
- Latency:
  - Pop: 1 cycle from sample_req to sample_valid.
  - Flash word to level increment: 1 cycle after flash_ready.
- sample_req is accepted every cycle. Back-to-back pops drain one word per cycle.

Optional Feature:
- Macro: AUDIO_PREFETCH_LOOP_EN.
- Defined: on reaching BASE_ADDR+SIZE, the fetch pointer wraps to BASE_ADDR and fetching continues. done stays 0 permanently.
- Not defined: on reaching BASE_ADDR+SIZE, the FSM enters S_DONE. No further requests are issued, and done=1 is held until reset.
  - The FIFO still drains normally; pops after it empties are underruns.

Test Plan:
1. Reset, enable=1, flash model with 3-cycle ready latency and rdata=addr -> requests at 0x000000,0x000004,...,0x00001c; level reaches 8; no request while level=8.
2. Full FIFO, one sample_req -> sample_valid next cycle with sample_data=32'h00000000; level 7; new request at addr 0x000020 issued.
3. Keep FIFO empty (enable=0), issue 3 sample_req -> sample_data=0, 3 underrun pulses, underrun_cnt=3; force 65535 prior underruns -> cnt stays 16'hffff.
4. SIZE=24'h000010, loop macro defined -> addresses 0x0,0x4,0x8,0xc,0x0,0x4...; done=0. Macro undefined -> exactly 4 requests, then done=1 and flash_valid=0 forever.
5. Push and pop in the same cycle at level=4 -> level remains 4; popped word is the oldest.
6. Assert resetn=0 while flash_valid=1 and deliver flash_ready in that cycle -> after reset level=0, flash_addr=BASE_ADDR, word not stored.

Source files
------------

// File: rtl/audio_prefetch.sv
// Flash-to-I2S prefetcher: walks a PCM region of flash and keeps a small stereo-word FIFO topped up.
// Define AUDIO_PREFETCH_LOOP_EN to wrap to BASE_ADDR at the end of the region instead of stopping.
module audio_prefetch #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter logic [23:0] SIZE      = 24'h0ea600,
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  output logic          flash_valid,
  output logic [23:0]   flash_addr,
  input  logic          flash_ready,
  input  logic [31:0]   flash_rdata,
  input  logic          sample_req,
  output logic [31:0]   sample_data,
  output logic          sample_valid,
  output logic          underrun,
  output logic [15:0]   underrun_cnt,
  output logic [AW:0]   level,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [23:0] END_ADDR = BASE_ADDR + SIZE;
  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          empty;
  logic [23:0]   next_addr;

  // flash_addr doubles as the fetch pointer; it only moves once a word lands
  assign push      = (state == S_REQ) && flash_ready;
  assign empty     = (level == '0);
  assign pop       = sample_req && !empty;
  assign next_addr = flash_addr + 24'd4;

  always_ff @(posedge clk) begin
    if (resetn && push) mem[wr_ptr] <= flash_rdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      flash_valid  <= 1'b0;
      flash_addr   <= BASE_ADDR;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      level        <= '0;
      done         <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      sample_valid <= sample_req;
      underrun     <= sample_req && empty;

      if (sample_req) begin
        if (empty) begin
          sample_data <= '0;
          if (underrun_cnt != 16'hffff) underrun_cnt <= underrun_cnt + 16'd1;
        end else begin
          sample_data <= mem[rd_ptr];
          rd_ptr      <= rd_ptr + AW'(1);
        end
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      case (state)
        S_IDLE: begin
          if (enable && level < FULL) begin
            state       <= S_REQ;
            flash_valid <= 1'b1;
          end
        end
        S_REQ: begin
          if (flash_ready) begin
            flash_valid <= 1'b0;
            state       <= S_IDLE;
            if (next_addr == END_ADDR) begin
`ifdef AUDIO_PREFETCH_LOOP_EN
              flash_addr <= BASE_ADDR;
`else
              flash_addr <= next_addr;
              state      <= S_DONE;
              done       <= 1'b1;
`endif
            end else begin
              flash_addr <= next_addr;
            end
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
